// File: rtl/dphy_tx_pkg.sv
// dphy_tx_pkg: shared definitions for the D-PHY HS transmit lane.
//   dphy_state_e : lane sequencer states
//   SYNC_BYTE    : HS leader sync pattern
//   LP_*         : low-power line encodings as {lp_dp, lp_dn}
//   is_hs_state  : true for states where the HS driver is enabled
package dphy_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LPX     = 3'd1,
    PREPARE = 3'd2,
    ZERO    = 3'd3,
    SYNC    = 3'd4,
    DATA    = 3'd5,
    TRAIL   = 3'd6,
    EXIT    = 3'd7
  } dphy_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  localparam logic [1:0] LP_11 = 2'b11;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_00 = 2'b00;

  function automatic logic is_hs_state(input dphy_state_e s);
    return (s == ZERO) || (s == SYNC) || (s == DATA) || (s == TRAIL);
  endfunction

endpackage

// File: rtl/dphy_tx_lane_if.sv
// dphy_tx_lane_if: byte-side handshake between a payload source and the lane.
//   tx_req     : request one HS burst
//   byte_data  : payload byte, LSB sent first
//   byte_valid : byte_data valid
//   byte_ready : lane takes byte_data this cycle if byte_valid is high
//   busy       : lane is not idle
// master = payload source, slave = lane.
interface dphy_tx_lane_if;
  logic       tx_req;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       busy;

  modport master (
    output tx_req, byte_data, byte_valid,
    input  byte_ready, busy
  );

  modport slave (
    input  tx_req, byte_data, byte_valid,
    output byte_ready, busy
  );
endinterface

// File: rtl/dphy_tx_byte_shifter.sv
// dphy_tx_byte_shifter: 8-bit serializer feeding two bits per cycle.
//   dphy_clk, areset : clock, async active-high reset
//   start            : load SYNC_BYTE, phase 0 (entry into SYNC)
//   advance          : consume one bit pair (SYNC/DATA cycles)
//   load, load_byte  : at phase 3, reload with load_byte when load is high
//   phase            : registered phase of the current cycle
//   pair_nxt         : bit pair that will be on the line next cycle
//   phase_nxt        : phase of the next cycle
//   last_bit_nxt     : last bit sent, as it will be next cycle
// The *_nxt outputs let the top register its outputs aligned with state.
module dphy_tx_byte_shifter
  import dphy_tx_pkg::*;
(
  input  logic       dphy_clk,
  input  logic       areset,
  input  logic       start,
  input  logic       advance,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic [1:0] phase,
  output logic [1:0] pair_nxt,
  output logic [1:0] phase_nxt,
  output logic       last_bit_nxt
);

  logic [7:0] sr_q, sr_d;
  logic [1:0] phase_q, phase_d;
  logic       last_q, last_d;

  always_comb begin
    sr_d    = sr_q;
    phase_d = phase_q;
    last_d  = last_q;
    if (start) begin
      sr_d    = SYNC_BYTE;
      phase_d = 2'd0;
    end else if (advance) begin
      if (phase_q == 2'd3) begin
        // sr_q[1] is the second bit of the final pair of this byte
        last_d  = sr_q[1];
        phase_d = 2'd0;
        sr_d    = load ? load_byte : 8'h00;
      end else begin
        sr_d    = {2'b00, sr_q[7:2]};
        phase_d = phase_q + 2'd1;
      end
    end
  end

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      sr_q    <= 8'h00;
      phase_q <= 2'd0;
      last_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      phase_q <= phase_d;
      last_q  <= last_d;
    end
  end

  assign phase        = phase_q;
  assign pair_nxt     = sr_d[1:0];
  assign phase_nxt    = phase_d;
  assign last_bit_nxt = last_d;

endmodule

// File: rtl/dphy_tx_lane.sv
// dphy_tx_lane: single D-PHY data lane transmitter (LP entry, HS burst, exit).
//   dphy_clk : HS bit clock, DDR output, rising-edge logic
//   areset   : async active-high reset
//   bus      : byte-side handshake (slave modport)
//   hs_dout  : DDR pair, [0] first bit of the cycle
//   lp_dp/dn : LP line levels
//   hs_oe    : HS driver enable
// All outputs are registered; they are computed from next-state values so
// they line up with the state register.
//
// state   | meaning
// IDLE    | LP-11 stop, waits for tx_req
// LPX     | LP-01 for T_LPX cycles
// PREPARE | LP-00 for T_HS_PREPARE cycles
// ZERO    | HS-0 preamble for T_HS_ZERO cycles
// SYNC    | sync byte, 4 cycles
// DATA    | payload bytes, 4 cycles each
// TRAIL   | inverted last bit for T_HS_TRAIL cycles
// EXIT    | LP-11 for T_LPX cycles
module dphy_tx_lane
  import dphy_tx_pkg::*;
#(
  parameter int   T_LPX        = 4,
  parameter int   T_HS_PREPARE = 3,
  parameter int   T_HS_ZERO    = 6,
  parameter int   T_HS_TRAIL   = 5,
  parameter logic INVERT       = 1'b0
) (
  input  logic           dphy_clk,
  input  logic           areset,
  dphy_tx_lane_if.slave  bus,
  output logic [1:0]     hs_dout,
  output logic           lp_dp,
  output logic           lp_dn,
  output logic           hs_oe
);

  localparam logic [7:0] LPX_LOAD   = 8'(T_LPX - 1);
  localparam logic [7:0] PREP_LOAD  = 8'(T_HS_PREPARE - 1);
  localparam logic [7:0] ZERO_LOAD  = 8'(T_HS_ZERO - 1);
  localparam logic [7:0] TRAIL_LOAD = 8'(T_HS_TRAIL - 1);

  dphy_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        cnt_done;

  logic        sh_start, sh_advance;
  logic [1:0]  phase, pair_nxt, phase_nxt;
  logic        last_nxt;

  logic [1:0]  lp_d, raw_d, hs_dout_d;
  logic        hs_oe_d, byte_ready_d, busy_d;

  assign cnt_done = (cnt_q == 8'd0);

  dphy_tx_byte_shifter u_shifter (
    .dphy_clk     (dphy_clk),
    .areset       (areset),
    .start        (sh_start),
    .advance      (sh_advance),
    .load         (bus.byte_valid),
    .load_byte    (bus.byte_data),
    .phase        (phase),
    .pair_nxt     (pair_nxt),
    .phase_nxt    (phase_nxt),
    .last_bit_nxt (last_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_done ? cnt_q : cnt_q - 8'd1;
    sh_start   = 1'b0;
    sh_advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.tx_req) begin
          state_d = LPX;
          cnt_d   = LPX_LOAD;
        end
      end
      LPX: begin
        if (cnt_done) begin
          state_d = PREPARE;
          cnt_d   = PREP_LOAD;
        end
      end
      PREPARE: begin
        if (cnt_done) begin
          state_d = ZERO;
          cnt_d   = ZERO_LOAD;
        end
      end
      ZERO: begin
        if (cnt_done) begin
          state_d  = SYNC;
          sh_start = 1'b1;
        end
      end
      SYNC, DATA: begin
        sh_advance = 1'b1;
        if (phase == 2'd3) begin
          if (bus.byte_valid) begin
            state_d = DATA;
          end else begin
            state_d = TRAIL;
            cnt_d   = TRAIL_LOAD;
          end
        end
      end
      TRAIL: begin
        if (cnt_done) begin
          state_d = EXIT;
          cnt_d   = LPX_LOAD;
        end
      end
      EXIT: begin
        if (cnt_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lp_d         = LP_11;
    raw_d        = 2'b00;
    byte_ready_d = 1'b0;
    hs_oe_d      = is_hs_state(state_d);
    busy_d       = (state_d != IDLE);
    case (state_d)
      LPX:     lp_d = LP_01;
      PREPARE: lp_d = LP_00;
      ZERO:    lp_d = LP_00;
      SYNC, DATA: begin
        lp_d         = LP_00;
        raw_d        = pair_nxt;
        byte_ready_d = (phase_nxt == 2'd3);
      end
      TRAIL: begin
        lp_d  = LP_00;
        raw_d = {2{~last_nxt}};
      end
      default: lp_d = LP_11;
    endcase
    // pair swap only matters while the HS driver owns the lines
    hs_dout_d = (hs_oe_d && INVERT) ? ~raw_d : raw_d;
  end

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      lp_dp          <= 1'b1;
      lp_dn          <= 1'b1;
      hs_oe          <= 1'b0;
      hs_dout        <= 2'b00;
      bus.byte_ready <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      {lp_dp, lp_dn} <= lp_d;
      hs_oe          <= hs_oe_d;
      hs_dout        <= hs_dout_d;
      bus.byte_ready <= byte_ready_d;
      bus.busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_dphy_tx_lane.sv
// tb_dphy_tx_lane: drives two lanes (INVERT=0 and INVERT=1) with the same
// stimulus and compares every cycle against an expected waveform built
// from the burst timing rules.
module tb_dphy_tx_lane;

  localparam int T_LPX        = 4;
  localparam int T_HS_PREPARE = 3;
  localparam int T_HS_ZERO    = 6;
  localparam int T_HS_TRAIL   = 5;

  logic       dphy_clk = 1'b0;
  logic       areset;
  logic [1:0] hs_dout0, hs_dout1;
  logic       lp_dp0, lp_dn0, hs_oe0;
  logic       lp_dp1, lp_dn1, hs_oe1;

  int checks = 0;
  int errors = 0;

  // {lp_dp, lp_dn, hs_oe, busy, byte_ready, hs_dout[1:0]}
  logic [6:0] exp_q[$];
  logic [7:0] bytes_q[$];
  logic [6:0] out0, out1;

  dphy_tx_lane_if bus0 ();
  dphy_tx_lane_if bus1 ();

  assign bus1.tx_req     = bus0.tx_req;
  assign bus1.byte_data  = bus0.byte_data;
  assign bus1.byte_valid = bus0.byte_valid;

  always #5 dphy_clk = ~dphy_clk;

  dphy_tx_lane #(
    .T_LPX(T_LPX), .T_HS_PREPARE(T_HS_PREPARE), .T_HS_ZERO(T_HS_ZERO),
    .T_HS_TRAIL(T_HS_TRAIL), .INVERT(1'b0)
  ) dut0 (
    .dphy_clk(dphy_clk), .areset(areset), .bus(bus0.slave),
    .hs_dout(hs_dout0), .lp_dp(lp_dp0), .lp_dn(lp_dn0), .hs_oe(hs_oe0)
  );

  dphy_tx_lane #(
    .T_LPX(T_LPX), .T_HS_PREPARE(T_HS_PREPARE), .T_HS_ZERO(T_HS_ZERO),
    .T_HS_TRAIL(T_HS_TRAIL), .INVERT(1'b1)
  ) dut1 (
    .dphy_clk(dphy_clk), .areset(areset), .bus(bus1.slave),
    .hs_dout(hs_dout1), .lp_dp(lp_dp1), .lp_dn(lp_dn1), .hs_oe(hs_oe1)
  );

  assign out0 = {lp_dp0, lp_dn0, hs_oe0, bus0.busy, bus0.byte_ready, hs_dout0};
  assign out1 = {lp_dp1, lp_dn1, hs_oe1, bus1.busy, bus1.byte_ready, hs_dout1};

  localparam logic [6:0] IDLE_VEC = 7'b1100000;

  task automatic check_val(input string tag, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ev(input logic dp, input logic dn, input logic oe,
                                    input logic bsy, input logic br, input logic [1:0] d);
    return {dp, dn, oe, bsy, br, d};
  endfunction

  // Swapped lane: HS levels complemented, LP cycles untouched.
  function automatic logic [6:0] inv_of(input logic [6:0] e);
    return e[4] ? {e[6:2], ~e[1:0]} : e;
  endfunction

  task automatic build_exp(input int n);
    logic [7:0] b;
    logic       last;
    exp_q.delete();
    last = 1'b0;
    repeat (T_LPX)        exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00));
    repeat (T_HS_PREPARE) exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    repeat (T_HS_ZERO)    exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00));
    for (int k = 0; k <= n; k++) begin
      b = (k == 0) ? 8'hB8 : bytes_q[k-1];
      for (int p = 0; p < 4; p++)
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b1, p == 3, {b[2*p+1], b[2*p]}));
      last = b[7];
    end
    repeat (T_HS_TRAIL)   exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, {~last, ~last}));
    repeat (T_LPX)        exp_q.push_back(ev(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00));
    exp_q.push_back(IDLE_VEC);
  endtask

  task automatic drive_bytes(input int idx, input int n);
    bus0.byte_valid = (idx < n);
    bus0.byte_data  = (idx < n) ? bytes_q[idx] : 8'($urandom);
  endtask

  // Called at #1 into an IDLE cycle. keep leaves tx_req high throughout;
  // abort_at >= 0 asserts areset in that cycle of the burst.
  task automatic run_burst(input int n, input bit keep, input int abort_at);
    int idx;
    bit acc;
    build_exp(n);
    idx = 0;
    acc = 1'b0;
    bus0.tx_req = 1'b1;
    drive_bytes(idx, n);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge dphy_clk); #1;
      if (acc) idx++;
      if (!keep) bus0.tx_req = 1'b0;
      check_val($sformatf("lane0 cyc%0d", i), out0, exp_q[i]);
      check_val($sformatf("lane1 cyc%0d", i), out1, inv_of(exp_q[i]));
      acc = exp_q[i][2] && (idx < n);
      drive_bytes(idx, n);
      if (i == abort_at) begin
        areset = 1'b1;
        #1;
        check_val("rst_now lane0", out0, IDLE_VEC);
        check_val("rst_now lane1", out1, IDLE_VEC);
        @(posedge dphy_clk); #1;
        check_val("rst_hold lane0", out0, IDLE_VEC);
        check_val("rst_hold lane1", out1, IDLE_VEC);
        bus0.tx_req = 1'b0;
        areset = 1'b0;
        return;
      end
    end
  endtask

  task automatic idle_gap(input int g);
    for (int i = 0; i < g; i++) begin
      @(posedge dphy_clk); #1;
      check_val("idle lane0", out0, IDLE_VEC);
      check_val("idle lane1", out1, IDLE_VEC);
    end
  endtask

  initial begin
    int  n;
    bit  keep;
    areset          = 1'b1;
    bus0.tx_req     = 1'b0;
    bus0.byte_valid = 1'b0;
    bus0.byte_data  = 8'h00;
    repeat (2) @(posedge dphy_clk);
    #1;
    check_val("reset lane0", out0, IDLE_VEC);
    check_val("reset lane1", out1, IDLE_VEC);
    areset = 1'b0;
    idle_gap(2);

    bytes_q = '{8'h2A};
    run_burst(1, 1'b0, -1);
    idle_gap(2);

    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_burst(4, 1'b0, -1);
    idle_gap(1);

    bytes_q.delete();
    run_burst(0, 1'b0, -1);

    bytes_q = '{8'h5C};
    run_burst(1, 1'b1, -1);
    run_burst(1, 1'b0, -1);
    idle_gap(1);

    // reset lands in DATA phase 2 of the first payload byte
    bytes_q = '{8'hA5, 8'h3C};
    run_burst(2, 1'b0, T_LPX + T_HS_PREPARE + T_HS_ZERO + 4 + 2);
    bytes_q = '{8'h96};
    run_burst(1, 1'b0, -1);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(0, 5);
      bytes_q.delete();
      repeat (n) bytes_q.push_back(8'($urandom));
      keep = ($urandom_range(0, 3) == 0) && (r != 24);
      run_burst(n, keep, -1);
      if (!keep) idle_gap($urandom_range(0, 3));
    end
    idle_gap(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
